// File: rtl/sequential_right_shifter_if.sv
// Operand/result handshake between the ALU sequencer (master) and the
// multi-cycle right shifter (slave).
interface sequential_right_shifter_if;
   logic        start;
   logic [31:0] data;
   logic [4:0]  shamt;
   logic        arith;
   logic [31:0] dataOut;
   logic        busy;
   logic        done;

   modport master (
      output start, data, shamt, arith,
      input  dataOut, busy, done
   );

   modport slave (
      input  start, data, shamt, arith,
      output dataOut, busy, done
   );
endinterface

// File: rtl/sequential_right_shifter.sv
// Multi-cycle 32-bit SRL/SRA: resolves one shamt bit per clock (1,2,4,8,16)
// on a single working register, with a start/busy/done handshake.
module sequential_right_shifter (
   input  logic                             clk,
   input  logic                             rst_n,
   sequential_right_shifter_if.slave        bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] work_q, work_d;
   logic [31:0] dout_q, dout_d;
   logic [4:0]  shamt_q, shamt_d;
   logic        fill_q, fill_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] stage_res;

   // Shift by 2^k, back-filling the vacated bits with the fill bit.
   function automatic logic [31:0] shift_stage(input logic [31:0] w,
                                               input logic [2:0]  k,
                                               input logic        fill);
      logic [63:0] ext;
      ext = {{32{fill}}, w} >> (6'd1 << k);
      return ext[31:0];
   endfunction

   always_comb begin
      stage_res = work_q;
      if (cnt_q <= 3'd4 && shamt_q[cnt_q])
         stage_res = shift_stage(work_q, cnt_q, fill_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      dout_d  = dout_q;
      shamt_d = shamt_q;
      fill_d  = fill_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               work_d  = bus.data;
               shamt_d = bus.shamt;
               // Fill is frozen from the original sign bit, never the shifting register.
               fill_d  = bus.arith & bus.data[31];
               cnt_d   = 3'd0;
               state_d = SHIFT;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            work_d = stage_res;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
               dout_d  = stage_res;
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         work_q  <= 32'h0;
         dout_q  <= 32'h0;
         shamt_q <= 5'd0;
         fill_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         dout_q  <= dout_d;
         shamt_q <= shamt_d;
         fill_q  <= fill_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.dataOut = dout_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
